// File: rtl/tracking_fifo.sv
// tracking_fifo: byte-wide single-clock FIFO for the PMOD DAC sample path.
// Write/read pointers and fill count are exposed so the DAC side can pace
// 4-byte frame pulls. An empty read returns 0x00 (silence) and raises a
// sticky underflow; a write into a full FIFO is dropped and raises overflow.
module tracking_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH-1:0] addr_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  flag_clear
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr, r_rptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_empty, r_full, r_ovf, r_udf;
  logic [DATA_WIDTH-1:0] r_dout;

  logic                  w_rd_acc, w_wr_acc, w_wr_drop, w_rd_under;
  logic [ADDR_WIDTH:0]   w_count_nxt;

  // A read at full frees a slot in the same cycle, so the write may ride on it.
  // No bypass: a read at empty underflows even if a write lands this cycle.
  assign w_rd_acc   = read & ~r_empty;
  assign w_wr_acc   = write & (~r_full | w_rd_acc);
  assign w_wr_drop  = write & ~w_wr_acc;
  assign w_rd_under = read & r_empty;

  // Next fill level; empty/full are registered from this, not from pointers.
  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_acc && !w_rd_acc)
      w_count_nxt = r_count + 1'b1;
    else if (w_rd_acc && !w_wr_acc)
      w_count_nxt = r_count - 1'b1;
  end

  // Storage write port; contents are never reset.
  always_ff @(posedge clk) begin
    if (!reset && w_wr_acc)
      r_mem[r_wptr] <= data_in;
  end

  // Registered read port: memory byte on accepted read, silence on underrun.
  always_ff @(posedge clk) begin
    if (reset)
      r_dout <= '0;
    else if (w_rd_acc)
      r_dout <= r_mem[r_rptr];
    else if (w_rd_under)
      r_dout <= '0;
  end

  // Pointers, fill level, status and sticky flags (set wins over clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == FULL_CNT);
      r_ovf   <= (r_ovf & ~flag_clear) | w_wr_drop;
      r_udf   <= (r_udf & ~flag_clear) | w_rd_under;
    end
  end

  assign data_out  = r_dout;
  assign addr_in   = r_wptr;
  assign addr_out  = r_rptr;
  assign count     = r_count;
  assign empty     = r_empty;
  assign full      = r_full;
  assign overflow  = r_ovf;
  assign underflow = r_udf;

endmodule
